arb_mux_rr: RTL and testbench



---
 rtl/arb_mux_rr_if.sv | 26 ++
 rtl/arb_mux_rr.sv | 99 +++++++++
 tb/tb_arb_mux_rr.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/arb_mux_rr_if.sv
// Valid/ready bundle for arb_mux_rr: NREQS producer channels in, one consumer channel out.
// The slave modport is the arbiter's view; the master modport is the producers/consumer side.
interface arb_mux_rr_if #(
    parameter int NBITS = 8,
    parameter int NREQS = 4
);
    localparam int SELW = (NREQS > 1) ? $clog2(NREQS) : 1;

    logic [NREQS-1:0]       in_val;
    logic [NREQS-1:0]       in_rdy;
    logic [NREQS*NBITS-1:0] in_msg;
    logic                   out_val;
    logic                   out_rdy;
    logic [NBITS-1:0]       out_msg;
    logic [SELW-1:0]        out_sel;

    modport master (
        output in_val, in_msg, out_rdy,
        input  in_rdy, out_val, out_msg, out_sel
    );

    modport slave (
        input  in_val, in_msg, out_rdy,
        output in_rdy, out_val, out_msg, out_sel
    );
endinterface

// File: rtl/arb_mux_rr.sv
// Round-robin N-input registered mux with a one-entry output register and valid/ready on every port.
// Define ARB_MUX_RR_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module arb_mux_rr #(
    parameter int NBITS = 8,
    parameter int NREQS = 4
) (
    input  logic         clk,
    input  logic         reset,
    arb_mux_rr_if.slave  bus
);
    localparam int SELW = (NREQS > 1) ? $clog2(NREQS) : 1;

    logic             full;
    logic [NBITS-1:0] msg;
    logic [SELW-1:0]  sel;

    logic             grant_vld;
    logic [SELW-1:0]  grant_idx;
    logic [NBITS-1:0] grant_msg;
    logic             can_accept;
    logic             xfer;

`ifndef ARB_MUX_RR_FIXED_PRIO_EN
    logic [SELW-1:0]  ptr;
    logic [SELW:0]    cand_sum;
    logic [SELW-1:0]  cand;
`endif

    assign can_accept = !full || bus.out_rdy;
    assign xfer       = can_accept && grant_vld && !reset;

`ifdef ARB_MUX_RR_FIXED_PRIO_EN
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQS; k++) begin
            if (!grant_vld && bus.in_val[k]) begin
                grant_vld = 1'b1;
                grant_idx = SELW'(k);
            end
        end
    end
`else
    // Search starts at ptr and wraps modulo NREQS; first valid channel wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = 0; k < NREQS; k++) begin
            cand_sum = {1'b0, ptr} + (SELW+1)'(k);
            if (cand_sum >= (SELW+1)'(NREQS))
                cand_sum = cand_sum - (SELW+1)'(NREQS);
            cand = cand_sum[SELW-1:0];
            if (!grant_vld && bus.in_val[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end
`endif

    always_comb begin
        grant_msg = '0;
        for (int k = 0; k < NREQS; k++) begin
            if (grant_idx == SELW'(k))
                grant_msg = bus.in_msg[k*NBITS +: NBITS];
        end
    end

    assign bus.in_rdy  = xfer ? (NREQS'(1) << grant_idx) : '0;
    assign bus.out_val = full;
    assign bus.out_msg = msg;
    assign bus.out_sel = sel;

    // A transfer reloads the entry even when it is draining this cycle, so there is no bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            msg  <= '0;
            sel  <= '0;
`ifndef ARB_MUX_RR_FIXED_PRIO_EN
            ptr  <= '0;
`endif
        end else if (xfer) begin
            full <= 1'b1;
            msg  <= grant_msg;
            sel  <= grant_idx;
`ifndef ARB_MUX_RR_FIXED_PRIO_EN
            if (grant_idx == SELW'(NREQS-1))
                ptr <= '0;
            else
                ptr <= grant_idx + SELW'(1);
`endif
        end else if (bus.out_rdy) begin
            full <= 1'b0;
        end
    end
endmodule

// File: tb/tb_arb_mux_rr.sv
// Directed bench for arb_mux_rr (NBITS=8, NREQS=4); expectations follow ARB_MUX_RR_FIXED_PRIO_EN if defined.
module tb_arb_mux_rr;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    arb_mux_rr_if #(.NBITS(8), .NREQS(4)) bus ();

    arb_mux_rr #(.NBITS(8), .NREQS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_msg(input int ch, input logic [7:0] m);
        bus.in_msg[ch*8 +: 8] = m;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] m, input logic [1:0] s);
        chk({tag, "_val"}, 32'(bus.out_val), 32'(v));
        chk({tag, "_msg"}, 32'(bus.out_msg), 32'(m));
        chk({tag, "_sel"}, 32'(bus.out_sel), 32'(s));
    endtask

    initial begin
        int exp_seq[6];
        int exp_bp;
`ifdef ARB_MUX_RR_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0, 0, 0};
        exp_bp  = 0;
`else
        exp_seq = '{0, 1, 2, 3, 0, 1};
        exp_bp  = 2;
`endif
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        bus.in_val  = 4'b0000;
        bus.in_msg  = '0;
        bus.out_rdy = 1'b0;

        // reset held two cycles, idle
        tick();
        tick();
        chk_out("reset", 1'b0, 8'h00, 2'd0);
        chk("reset_in_rdy", 32'(bus.in_rdy), 32'h0);
        bus.in_val  = 4'b1111;
        bus.out_rdy = 1'b1;
        #1;
        chk("reset_in_rdy_req", 32'(bus.in_rdy), 32'h0);

        // fairness: all channels valid, consumer always ready
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) set_msg(c, 8'(8'h10 + c));
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("rr_in_rdy", 32'(bus.in_rdy), 32'(4'b0001 << exp_seq[i]));
            tick();
            chk_out("rr_out", 1'b1, 8'(8'h10 + exp_seq[i]), 2'(exp_seq[i]));
        end

        // backpressure: entry full, consumer stalls for three cycles
        bus.out_rdy = 1'b0;
        #1;
        chk("bp_in_rdy", 32'(bus.in_rdy), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("bp_hold", 1'b1, 8'(8'h10 + exp_seq[5]), 2'(exp_seq[5]));
            chk("bp_in_rdy_hold", 32'(bus.in_rdy), 32'h0);
        end
        bus.out_rdy = 1'b1;
        #1;
        chk("bp_release_in_rdy", 32'(bus.in_rdy), 32'(4'b0001 << exp_bp));
        tick();
        chk_out("bp_release_out", 1'b1, 8'(8'h10 + exp_bp), 2'(exp_bp));

        // single requester on channel 2
        bus.in_val = 4'b0100;
        set_msg(2, 8'hA5);
        #1;
        chk("single_in_rdy", 32'(bus.in_rdy), 32'b0100);
        tick();
        chk_out("single_out", 1'b1, 8'hA5, 2'd2);
        bus.in_val = 4'b0000;
        tick();
        chk_out("drain_hold", 1'b0, 8'hA5, 2'd2);

        // wrap from ptr=3 to channel 0, then channel 1
        set_msg(0, 8'h30);
        set_msg(1, 8'h31);
        bus.in_val = 4'b0011;
        #1;
        chk("wrap_in_rdy0", 32'(bus.in_rdy), 32'b0001);
        tick();
        chk_out("wrap_out0", 1'b1, 8'h30, 2'd0);
        bus.in_val = 4'b0010;
        #1;
        chk("wrap_in_rdy1", 32'(bus.in_rdy), 32'b0010);
        tick();
        chk_out("wrap_out1", 1'b1, 8'h31, 2'd1);
        bus.in_val = 4'b0000;
        tick();
        chk("wrap_drain_val", 32'(bus.out_val), 32'h0);

        // reset while holding a message
        set_msg(1, 8'h22);
        bus.in_val  = 4'b0010;
        bus.out_rdy = 1'b0;
        #1;
        chk("mid_in_rdy", 32'(bus.in_rdy), 32'b0010);
        tick();
        chk_out("mid_full", 1'b1, 8'h22, 2'd1);
        bus.in_val = 4'b0000;
        reset      = 1'b1;
        tick();
        chk_out("mid_reset", 1'b0, 8'h00, 2'd0);
        reset = 1'b0;
        set_msg(0, 8'h55);
        set_msg(2, 8'h66);
        bus.in_val  = 4'b0101;
        bus.out_rdy = 1'b1;
        #1;
        chk("post_reset_in_rdy", 32'(bus.in_rdy), 32'b0001);
        tick();
        chk_out("post_reset_out", 1'b1, 8'h55, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
